// File: rtl/sa_out_arb_22.sv
// sa_out_arb_22 -- output-port switch allocator for node 22.
// Three show-ahead input FIFOs (N, W, L) compete for one output link.
// Arbitration is per packet: the winner's head flit locks the output until its
// tail flit has been popped. The winner is the candidate with the highest pressure,
// with round-robin order breaking ties. A one-entry registered stage drives the
// downstream router FIFO.
module sa_out_arb_22 #(
  parameter int WIDTH       = 3,     // pressure buses are WIDTH+1 bits
  parameter int DATASIZE    = 40,    // flit width, type in the top two bits
  parameter bit PRESSURE_EN = 1'b1   // 1: pressure first, 0: pure round-robin
) (
  input  logic                fifo_clk,
  input  logic                rst_n,
  // North input FIFO
  input  logic [DATASIZE-1:0] N_data_in,
  input  logic                N_valid_in,
  input  logic [WIDTH:0]      N_pressure_in,
  input  logic                N_req,
  output logic                fifo_ready_N,
  // West input FIFO
  input  logic [DATASIZE-1:0] W_data_in,
  input  logic                W_valid_in,
  input  logic [WIDTH:0]      W_pressure_in,
  input  logic                W_req,
  output logic                fifo_ready_W,
  // Local input FIFO
  input  logic [DATASIZE-1:0] L_data_in,
  input  logic                L_valid_in,
  input  logic [WIDTH:0]      L_pressure_in,
  input  logic                L_req,
  output logic                fifo_ready_L,
  // Output stage toward the downstream FIFO
  output logic [DATASIZE-1:0] out_data,
  output logic                out_valid,
  input  logic                out_full,
  // Status
  output logic [2:0]          grant,
  output logic                proto_err
);

  localparam int NUM_IN = 3;

  // Input indices; grant bit i belongs to input i, giving {L,W,N}.
  localparam logic [1:0] PORT_N = 2'd0;
  localparam logic [1:0] PORT_W = 2'd1;
  localparam logic [1:0] PORT_L = 2'd2;

  // Flit type encodings (top two bits of a flit).
  localparam logic [1:0] FT_BODY   = 2'b00;
  localparam logic [1:0] FT_TAIL   = 2'b01;
  localparam logic [1:0] FT_HEAD   = 2'b10;
  localparam logic [1:0] FT_SINGLE = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,   // no packet owns the output
    ST_LOCK = 1'b1    // owner_q streams body flits until its tail
  } state_e;

  // --------------------------------------------------------------------------
  // Helpers
  // --------------------------------------------------------------------------

  // Input index that sits 'offs' places after 'base' in the cyclic order N,W,L.
  function automatic logic [1:0] rr_idx(input logic [1:0] base, input logic [1:0] offs);
    logic [2:0] sum;
    sum = {1'b0, base} + {1'b0, offs};
    if (sum >= 3'd3) sum = sum - 3'd3;
    return sum[1:0];
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] idx);
    return 3'b001 << idx;
  endfunction

  // --------------------------------------------------------------------------
  // Input gathering: index the three inputs uniformly
  // --------------------------------------------------------------------------
  logic [DATASIZE-1:0] data_in  [NUM_IN];
  logic [WIDTH:0]      pres_in  [NUM_IN];
  logic [1:0]          ftype_in [NUM_IN];
  logic [NUM_IN-1:0]   valid_in;
  logic [NUM_IN-1:0]   req_in;

  assign data_in[PORT_N] = N_data_in;
  assign data_in[PORT_W] = W_data_in;
  assign data_in[PORT_L] = L_data_in;

  assign pres_in[PORT_N] = N_pressure_in;
  assign pres_in[PORT_W] = W_pressure_in;
  assign pres_in[PORT_L] = L_pressure_in;

  assign valid_in = {L_valid_in, W_valid_in, N_valid_in};
  assign req_in   = {L_req, W_req, N_req};

  for (genvar g = 0; g < NUM_IN; g++) begin : g_ftype
    assign ftype_in[g] = data_in[g][DATASIZE-1 -: 2];
  end

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_e              state_q,     state_d;
  logic [1:0]          owner_q,     owner_d;     // locked input while in ST_LOCK
  logic [1:0]          rr_q,        rr_d;        // highest round-robin priority
  logic [2:0]          grant_q,     grant_d;
  logic                err_q,       err_d;
  logic                out_valid_q, out_valid_d;
  logic [DATASIZE-1:0] out_data_q,  out_data_d;

  // The output stage can take a new flit when it is empty or being drained.
  logic load;
  assign load = !out_valid_q || !out_full;

  // --------------------------------------------------------------------------
  // Head-flit arbitration among idle-state candidates
  // --------------------------------------------------------------------------
  logic [NUM_IN-1:0] cand;       // valid, requesting, head or single flit
  logic [NUM_IN-1:0] bad_head;   // valid, requesting, but body or tail flit
  logic              win_found;
  logic [1:0]        win_idx;
  logic [WIDTH:0]    win_pres;
  logic [1:0]        scan_idx;

  // Scan inputs in round-robin order; a later input only displaces the current
  // pick with a strictly higher pressure, so ties stay with the earlier input.
  always_comb begin
    // NOTE: every variable written here gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    cand      = '0;
    bad_head  = '0;
    win_found = 1'b0;
    win_idx   = PORT_N;
    win_pres  = '0;
    scan_idx  = PORT_N;
    for (int i = 0; i < NUM_IN; i++) begin
      cand[i]     = valid_in[i] && req_in[i] &&  ftype_in[i][1];
      bad_head[i] = valid_in[i] && req_in[i] && !ftype_in[i][1];
    end
    for (int k = 0; k < NUM_IN; k++) begin
      scan_idx = rr_idx(rr_q, 2'(k));
      if (cand[scan_idx] &&
          (!win_found || (PRESSURE_EN && (pres_in[scan_idx] > win_pres)))) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
        win_pres  = pres_in[scan_idx];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Lock FSM: picks which input is popped this cycle and tracks packet ownership
  // --------------------------------------------------------------------------
  logic [NUM_IN-1:0] pop_vec;
  logic [1:0]        pop_idx;
  logic              pop_any;

  // Next-state, pop selection, round-robin update and error detection.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    err_d   = err_q;
    pop_vec = '0;
    pop_idx = PORT_N;

    case (state_q)
      ST_IDLE: begin
        // A body or tail flit at the head of an idle input means a packet
        // lost its head; flag it and leave that FIFO untouched.
        if (|bad_head) err_d = 1'b1;
        if (win_found && load) begin
          pop_vec[win_idx] = 1'b1;
          pop_idx          = win_idx;
          if (ftype_in[win_idx] == FT_HEAD) begin
            state_d = ST_LOCK;
            owner_d = win_idx;
            grant_d = onehot(win_idx);
          end else begin
            // Single-flit packet: done in one pop, never locks.
            rr_d = rr_idx(win_idx, 2'd1);
          end
        end
      end

      ST_LOCK: begin
        // Requests are ignored; only the owner is served, stalling while empty.
        if (valid_in[owner_q] && load) begin
          pop_vec[owner_q] = 1'b1;
          pop_idx          = owner_q;
          if (ftype_in[owner_q] != FT_BODY) begin
            // Tail ends the packet. A head or single here is a protocol error,
            // but it is still forwarded and closes the packet like a tail.
            state_d = ST_IDLE;
            grant_d = '0;
            rr_d    = rr_idx(owner_q, 2'd1);
            if (ftype_in[owner_q][1]) err_d = 1'b1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign pop_any = |pop_vec;

  // --------------------------------------------------------------------------
  // Output stage
  // --------------------------------------------------------------------------

  // Register a popped flit when the stage can load; drain to empty otherwise.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (load) begin
      if (pop_any) begin
        out_valid_d = 1'b1;
        out_data_d  = data_in[pop_idx];
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge fifo_clk) begin
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      owner_q     <= PORT_N;
      rr_q        <= PORT_N;
      grant_q     <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_q        <= rr_d;
      grant_q     <= grant_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------

  // Pop strobes are suppressed while reset is held so no FIFO is drained by a
  // state that is about to be cleared.
  assign fifo_ready_N = pop_vec[PORT_N] && rst_n;
  assign fifo_ready_W = pop_vec[PORT_W] && rst_n;
  assign fifo_ready_L = pop_vec[PORT_L] && rst_n;

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign grant     = grant_q;
  assign proto_err = err_q;

endmodule

// File: tb/tb_sa_out_arb_22.sv
// Self-checking bench for sa_out_arb_22. Two instances are driven with the same
// inputs: dut_p (pressure-first) and dut_r (pure round-robin); 'pen' selects
// which one the reference model is checked against. Input FIFOs are modelled as
// queues whose heads drive the show-ahead data/valid inputs.
module tb_sa_out_arb_22;

  localparam int W  = 3;
  localparam int DS = 40;

  logic fifo_clk = 1'b0;
  always #5 fifo_clk = ~fifo_clk;

  logic          rst_n;
  logic [DS-1:0] d_in [3];
  logic [2:0]    v_in;
  logic [2:0]    r_in;
  logic [W:0]    p_in [3];
  logic          out_full;

  logic [2:0]    rdy_p, rdy_r;
  logic [DS-1:0] data_p, data_r;
  logic          valid_p, valid_r;
  logic [2:0]    grant_p, grant_r;
  logic          err_p, err_r;

  sa_out_arb_22 #(.WIDTH(W), .DATASIZE(DS), .PRESSURE_EN(1'b1)) dut_p (
    .fifo_clk(fifo_clk), .rst_n(rst_n),
    .N_data_in(d_in[0]), .N_valid_in(v_in[0]), .N_pressure_in(p_in[0]), .N_req(r_in[0]),
    .fifo_ready_N(rdy_p[0]),
    .W_data_in(d_in[1]), .W_valid_in(v_in[1]), .W_pressure_in(p_in[1]), .W_req(r_in[1]),
    .fifo_ready_W(rdy_p[1]),
    .L_data_in(d_in[2]), .L_valid_in(v_in[2]), .L_pressure_in(p_in[2]), .L_req(r_in[2]),
    .fifo_ready_L(rdy_p[2]),
    .out_data(data_p), .out_valid(valid_p), .out_full(out_full),
    .grant(grant_p), .proto_err(err_p)
  );

  sa_out_arb_22 #(.WIDTH(W), .DATASIZE(DS), .PRESSURE_EN(1'b0)) dut_r (
    .fifo_clk(fifo_clk), .rst_n(rst_n),
    .N_data_in(d_in[0]), .N_valid_in(v_in[0]), .N_pressure_in(p_in[0]), .N_req(r_in[0]),
    .fifo_ready_N(rdy_r[0]),
    .W_data_in(d_in[1]), .W_valid_in(v_in[1]), .W_pressure_in(p_in[1]), .W_req(r_in[1]),
    .fifo_ready_W(rdy_r[1]),
    .L_data_in(d_in[2]), .L_valid_in(v_in[2]), .L_pressure_in(p_in[2]), .L_req(r_in[2]),
    .fifo_ready_L(rdy_r[2]),
    .out_data(data_r), .out_valid(valid_r), .out_full(out_full),
    .grant(grant_r), .proto_err(err_r)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Stimulus state
  bit            pen = 1'b1;
  logic [DS-1:0] fq [3][$];     // input FIFO contents, index 0 = head
  bit            req_v  [3];
  logic [W:0]    pres_v [3];
  bit            full_v = 1'b0;
  logic [DS-1:0] rcv [$];       // flits accepted downstream

  // Reference model: packet-level rules, priority given by the last finisher
  bit            m_busy  = 1'b0;
  int            m_owner = 0;
  int            m_last  = 2;   // order after it: (m_last+1)%3, (m_last+2)%3, m_last
  bit            m_valid = 1'b0;
  logic [DS-1:0] m_data  = '0;
  logic [2:0]    m_grant = '0;
  bit            m_err   = 1'b0;
  int            exp_pop;
  bit            err_now;
  bit            load_m;

  // Observed / expected per cycle
  logic [2:0]    obs_ready, exp_ready;
  logic          obs_valid, obs_err;
  logic [DS-1:0] obs_data;
  logic [2:0]    obs_grant;
  logic [47:0]   obs_vec, exp_vec;

  function automatic logic [DS-1:0] mk(input logic [1:0] t);
    logic [DS-1:0] r;
    r = DS'({$urandom(), $urandom()});
    r[DS-1 -: 2] = t;
    return r;
  endfunction

  task automatic push_pkt(input int port, input int len);
    if (len == 1) fq[port].push_back(mk(2'b11));
    else begin
      fq[port].push_back(mk(2'b10));
      for (int b = 0; b < len - 2; b++) fq[port].push_back(mk(2'b00));
      fq[port].push_back(mk(2'b01));
    end
  endtask

  task automatic model_comb();
    int best;
    int i;
    logic [DS-1:0] h;
    logic [1:0] t;
    exp_pop = -1;
    err_now = 1'b0;
    load_m  = !m_valid || !full_v;
    if (rst_n) begin
      if (!m_busy) begin
        best = -1;
        for (int k = 0; k < 3; k++) begin
          i = (m_last + 1 + k) % 3;
          if (fq[i].size() > 0 && req_v[i]) begin
            h = fq[i][0];
            t = h[DS-1 -: 2];
            if (t == 2'b00 || t == 2'b01) err_now = 1'b1;
            else if (best < 0 || (pen && pres_v[i] > pres_v[best])) best = i;
          end
        end
        if (load_m && best >= 0) exp_pop = best;
      end else if (load_m && fq[m_owner].size() > 0) begin
        exp_pop = m_owner;
      end
    end
    exp_ready = (exp_pop >= 0) ? (3'b001 << exp_pop) : 3'b000;
    exp_vec   = {exp_ready, m_valid, m_data, m_grant, m_err};
  endtask

  task automatic model_seq();
    logic [DS-1:0] f;
    logic [1:0] t;
    if (!rst_n) begin
      m_busy = 1'b0; m_owner = 0; m_last = 2;
      m_valid = 1'b0; m_data = '0; m_grant = '0; m_err = 1'b0;
      return;
    end
    if (err_now) m_err = 1'b1;
    if (exp_pop >= 0) begin
      f = fq[exp_pop].pop_front();
      t = f[DS-1 -: 2];
      if (!m_busy) begin
        if (t == 2'b10) begin
          m_busy = 1'b1; m_owner = exp_pop; m_grant = 3'b001 << exp_pop;
        end else m_last = exp_pop;
      end else if (t != 2'b00) begin
        m_busy = 1'b0; m_grant = '0; m_last = m_owner;
        if (t[1]) m_err = 1'b1;
      end
      m_data  = f;
      m_valid = 1'b1;
    end else if (load_m) begin
      m_valid = 1'b0;
    end
  endtask

  // One clock: drive from the queues after the falling edge, sample, advance.
  task automatic cycle();
    for (int i = 0; i < 3; i++) begin
      v_in[i] = fq[i].size() > 0;
      d_in[i] = v_in[i] ? fq[i][0] : DS'({$urandom(), $urandom()});
      r_in[i] = req_v[i];
      p_in[i] = pres_v[i];
    end
    out_full = full_v;
    #1;
    model_comb();
    obs_ready = pen ? rdy_p   : rdy_r;
    obs_valid = pen ? valid_p : valid_r;
    obs_data  = pen ? data_p  : data_r;
    obs_grant = pen ? grant_p : grant_r;
    obs_err   = pen ? err_p   : err_r;
    obs_vec   = {obs_ready, obs_valid, obs_data, obs_grant, obs_err};
    @(posedge fifo_clk);
    if (rst_n && obs_valid && !full_v) rcv.push_back(obs_data);
    model_seq();
    @(negedge fifo_clk);
  endtask

  task automatic set_inputs(input bit rq, input logic [W:0] pn, input logic [W:0] pw,
                            input logic [W:0] pl);
    for (int i = 0; i < 3; i++) req_v[i] = rq;
    pres_v[0] = pn; pres_v[1] = pw; pres_v[2] = pl;
    full_v = 1'b0;
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) fq[i].delete();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    rcv.delete();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    set_inputs(1'b1, 4'd1, 4'd2, 4'd3);
    for (int i = 0; i < 3; i++) push_pkt(i, 1);
    rst_n = 1'b0;
    cycle();
    cycle();
    if (obs_ready !== 3'b000) begin n_fail++; $display("FAIL reset_ready got=%b exp=000", obs_ready); end
    n_tests++;
    if ({obs_valid, obs_data, obs_grant, obs_err} !== {1'b0, {DS{1'b0}}, 3'b000, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_regs got v=%b d=%h g=%b e=%b exp all zero", obs_valid, obs_data, obs_grant, obs_err);
    end
    n_tests++;
    for (int i = 0; i < 3; i++) fq[i].delete();
    rst_n = 1'b1;
  endtask

  task automatic test_single_l();
    logic [DS-1:0] flit;
    pen = 1'b1;
    do_reset();
    set_inputs(1'b1, 4'd0, 4'd0, 4'd0);
    flit = mk(2'b11);
    fq[2].push_back(flit);
    for (int c = 1; c <= 3; c++) begin
      cycle();
      if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL single_l_model c=%0d got=%h exp=%h", c, obs_vec, exp_vec); end
      n_tests++;
      if (c == 1 && {obs_ready, obs_grant} !== {3'b100, 3'b000}) begin
        n_fail++; $display("FAIL single_l_pop got rdy=%b g=%b exp rdy=100 g=000", obs_ready, obs_grant);
      end
      if (c == 1) n_tests++;
      if (c == 2 && {obs_ready, obs_valid, obs_data, obs_grant} !== {3'b000, 1'b1, flit, 3'b000}) begin
        n_fail++; $display("FAIL single_l_out got rdy=%b v=%b d=%h g=%b exp d=%h", obs_ready, obs_valid, obs_data, obs_grant, flit);
      end
      if (c == 2) n_tests++;
    end
  endtask

  task automatic test_wormhole();
    logic [2:0] rdy_tab [7];
    logic [2:0] gnt_tab [7];
    rdy_tab = '{3'b001, 3'b001, 3'b001, 3'b010, 3'b010, 3'b000, 3'b000};
    gnt_tab = '{3'b000, 3'b001, 3'b001, 3'b000, 3'b010, 3'b000, 3'b000};
    pen = 1'b1;
    do_reset();
    set_inputs(1'b1, 4'd0, 4'd0, 4'd0);
    push_pkt(0, 3);
    push_pkt(1, 2);
    for (int c = 0; c < 7; c++) begin
      cycle();
      if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL worm_model c=%0d got=%h exp=%h", c, obs_vec, exp_vec); end
      n_tests++;
      if (obs_ready !== rdy_tab[c] || obs_grant !== gnt_tab[c]) begin
        n_fail++; $display("FAIL worm_seq c=%0d got rdy=%b g=%b exp rdy=%b g=%b", c, obs_ready, obs_grant, rdy_tab[c], gnt_tab[c]);
      end
      n_tests++;
    end
  endtask

  task automatic test_pressure();
    logic [2:0] rdy_tab [7];
    logic [2:0] gnt_tab [7];
    rdy_tab = '{3'b010, 3'b010, 3'b100, 3'b100, 3'b001, 3'b001, 3'b000};
    gnt_tab = '{3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001, 3'b000};
    pen = 1'b1;
    do_reset();
    set_inputs(1'b1, 4'd2, 4'd6, 4'd6);
    for (int i = 0; i < 3; i++) push_pkt(i, 2);
    for (int c = 0; c < 7; c++) begin
      cycle();
      if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL press_model c=%0d got=%h exp=%h", c, obs_vec, exp_vec); end
      n_tests++;
      if (obs_ready !== rdy_tab[c] || obs_grant !== gnt_tab[c]) begin
        n_fail++; $display("FAIL press_seq c=%0d got rdy=%b g=%b exp rdy=%b g=%b", c, obs_ready, obs_grant, rdy_tab[c], gnt_tab[c]);
      end
      n_tests++;
    end
  endtask

  task automatic test_backpressure();
    logic [DS-1:0] sent [$];
    pen = 1'b1;
    do_reset();
    set_inputs(1'b1, 4'd0, 4'd0, 4'd0);
    push_pkt(0, 6);
    sent = fq[0];
    for (int c = 1; c <= 14; c++) begin
      full_v = (c >= 4 && c <= 7);
      cycle();
      if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL bp_model c=%0d got=%h exp=%h", c, obs_vec, exp_vec); end
      n_tests++;
      if (c >= 4 && c <= 7) begin
        if ({obs_ready, obs_valid, obs_data} !== {3'b000, 1'b1, sent[2]}) begin
          n_fail++; $display("FAIL bp_hold c=%0d got rdy=%b v=%b d=%h exp rdy=000 v=1 d=%h", c, obs_ready, obs_valid, obs_data, sent[2]);
        end
        n_tests++;
      end
      if (c == 8) begin
        if (obs_ready !== 3'b001) begin n_fail++; $display("FAIL bp_resume got rdy=%b exp 001", obs_ready); end
        n_tests++;
      end
    end
    if (rcv.size() != sent.size()) begin
      n_fail++; $display("FAIL bp_count got=%0d exp=%0d", rcv.size(), sent.size());
    end else begin
      for (int i = 0; i < sent.size(); i++)
        if (rcv[i] !== sent[i]) begin n_fail++; $display("FAIL bp_flit i=%0d got=%h exp=%h", i, rcv[i], sent[i]); end
    end
    n_tests++;
  endtask

  task automatic test_errors();
    pen = 1'b1;
    do_reset();
    set_inputs(1'b1, 4'd0, 4'd0, 4'd0);
    fq[1].push_back(mk(2'b00));
    cycle();
    if (obs_ready !== 3'b000) begin n_fail++; $display("FAIL err_nopop got rdy=%b exp 000", obs_ready); end
    n_tests++;
    cycle();
    if ({obs_ready, obs_err} !== {3'b000, 1'b1}) begin n_fail++; $display("FAIL err_flag got rdy=%b e=%b exp rdy=000 e=1", obs_ready, obs_err); end
    n_tests++;
    fq[1].delete();
    // Head inside a locked packet: forwarded, and it closes the packet.
    fq[0].push_back(mk(2'b10));
    fq[0].push_back(mk(2'b10));
    for (int c = 0; c < 3; c++) begin
      cycle();
      if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL err_lock_model c=%0d got=%h exp=%h", c, obs_vec, exp_vec); end
      n_tests++;
    end
    if ({obs_grant, obs_err, obs_valid} !== {3'b000, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL err_lock_release got g=%b e=%b v=%b exp g=000 e=1 v=1", obs_grant, obs_err, obs_valid);
    end
    n_tests++;
    // Reset in the middle of a locked packet.
    push_pkt(0, 5);
    cycle();
    cycle();
    if (obs_grant !== 3'b001) begin n_fail++; $display("FAIL rst_lock_pre got g=%b exp 001", obs_grant); end
    n_tests++;
    rst_n = 1'b0;
    cycle();
    if (obs_ready !== 3'b000) begin n_fail++; $display("FAIL rst_lock_ready got rdy=%b exp 000", obs_ready); end
    n_tests++;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) fq[i].delete();
    cycle();
    if ({obs_grant, obs_valid, obs_err} !== {3'b000, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL rst_lock_post got g=%b v=%b e=%b exp all zero", obs_grant, obs_valid, obs_err);
    end
    n_tests++;
  endtask

  task automatic test_round_robin();
    logic [2:0] rdy_tab [10];
    rdy_tab = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b000};
    pen = 1'b0;
    do_reset();
    set_inputs(1'b1, 4'd1, 4'd8, 4'd5);
    for (int i = 0; i < 3; i++) for (int k = 0; k < 3; k++) push_pkt(i, 1);
    for (int c = 0; c < 10; c++) begin
      pres_v[c % 3] = 4'($urandom_range(8, 0));
      cycle();
      if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL rr_model c=%0d got=%h exp=%h", c, obs_vec, exp_vec); end
      n_tests++;
      if (obs_ready !== rdy_tab[c] || obs_grant !== 3'b000 || (c > 0 && obs_valid !== 1'b1)) begin
        n_fail++; $display("FAIL rr_seq c=%0d got rdy=%b g=%b v=%b exp rdy=%b g=000", c, obs_ready, obs_grant, obs_valid, rdy_tab[c]);
      end
      n_tests++;
    end
  endtask

  task automatic test_random(input bit p);
    int guard;
    pen = p;
    do_reset();
    set_inputs(1'b1, 4'd0, 4'd0, 4'd0);
    for (int c = 0; c < 300; c++) begin
      if ($urandom_range(2, 0) == 0) begin
        int port;
        port = $urandom_range(2, 0);
        if (fq[port].size() < 8) push_pkt(port, $urandom_range(4, 1));
      end
      for (int i = 0; i < 3; i++) begin
        req_v[i]  = ($urandom_range(7, 0) != 0);
        pres_v[i] = 4'($urandom_range(8, 0));
      end
      full_v = ($urandom_range(3, 0) == 0);
      cycle();
      if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL rand_model pen=%0d c=%0d got=%h exp=%h", p, c, obs_vec, exp_vec); end
      n_tests++;
    end
    set_inputs(1'b1, 4'd0, 4'd0, 4'd0);
    guard = 0;
    while ((fq[0].size() + fq[1].size() + fq[2].size()) > 0 && guard < 300) begin
      cycle();
      if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL rand_drain pen=%0d got=%h exp=%h", p, obs_vec, exp_vec); end
      n_tests++;
      guard++;
    end
    if (guard >= 300) begin n_fail++; $display("FAIL rand_drain_timeout pen=%0d got=%0d left exp=0", p, fq[0].size() + fq[1].size() + fq[2].size()); end
    n_tests++;
  endtask

  initial begin
    rst_n = 1'b0;
    set_inputs(1'b0, 4'd0, 4'd0, 4'd0);
    @(negedge fifo_clk);
    test_reset();
    test_single_l();
    test_wormhole();
    test_pressure();
    test_backpressure();
    test_errors();
    test_round_robin();
    test_random(1'b1);
    test_random(1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
